// File: rtl/keypad_pkg.sv
// Shared types and constants for the calculator keypad front end.
package keypad_pkg;

   localparam int unsigned NUM_BUTTONS = 9;
   localparam logic [3:0]  DIGIT_MAX   = 4'd9;

   localparam int unsigned BTN_A_ONES = 0;
   localparam int unsigned BTN_A_TENS = 1;
   localparam int unsigned BTN_B_ONES = 2;
   localparam int unsigned BTN_B_TENS = 3;
   localparam int unsigned BTN_ADD    = 4;
   localparam int unsigned BTN_SUB    = 5;
   localparam int unsigned BTN_MUL    = 6;
   localparam int unsigned BTN_DIV    = 7;
   localparam int unsigned BTN_SHOW   = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= DIGIT_MAX) ? '0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/keypad_entry_debouncer.sv
// One button: 2-flop synchronizer, stability counter, debounced level and rising-edge flag.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic resetN,
   input  logic raw,
   output logic state,
   output logic rise
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             db;
   logic             db_prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         db_prev <= db;
         // The flip happens on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign state = db;
   assign rise  = db & ~db_prev;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced press strobes, BCD operand digits, operator latch, show flag.
// Optional digit auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 20000000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [8:0] buttons,
   output logic [3:0] opAOnes,
   output logic [3:0] opATens,
   output logic [3:0] opBOnes,
   output logic [3:0] opBTens,
   output logic [1:0] opSel,
   output logic       showResult,
   output logic [8:0] pressPulse,
   output logic       entryChanged
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("keypad_entry: invalid timing parameters");
   end

   logic [NUM_BUTTONS-1:0] held;
   logic [NUM_BUTTONS-1:0] rise;
   logic [NUM_BUTTONS-1:0] rep;
   logic [NUM_BUTTONS-1:0] strobe;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .resetN (resetN),
         .raw    (buttons[i]),
         .state  (held[i]),
         .rise   (rise[i])
      );
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [31:0] rep_cnt [4];
   logic [3:0]  rep_first;

   always_comb begin
      rep = '0;
      for (int unsigned i = BTN_A_ONES; i <= BTN_B_TENS; i++) begin
         rep[i] = held[i] && !rise[i] &&
                  (rep_cnt[i] == (rep_first[i] ? REPEAT_DELAY : REPEAT_PERIOD));
      end
   end

   // Counter reads 1 in the cycle after a press or repeat, so the next strobe lands exactly DELAY/PERIOD later.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rep_cnt   <= '{default: '0};
         rep_first <= '1;
      end else begin
         for (int unsigned i = BTN_A_ONES; i <= BTN_B_TENS; i++) begin
            if (!held[i]) begin
               rep_cnt[i]   <= '0;
               rep_first[i] <= 1'b1;
            end else if (rise[i]) begin
               rep_cnt[i]   <= 32'd1;
               rep_first[i] <= 1'b1;
            end else if (rep[i]) begin
               rep_cnt[i]   <= 32'd1;
               rep_first[i] <= 1'b0;
            end else begin
               rep_cnt[i]   <= rep_cnt[i] + 32'd1;
            end
         end
      end
   end
`else
   assign rep = '0;
`endif

   // rise already implies held; the mask keeps both debouncer outputs in use in every build.
   assign strobe = (rise | rep) & held;

   logic [3:0]             digit_q    [4];
   logic [3:0]             digit_next [4];
   op_t                    op_q;
   op_t                    op_next;
   logic                   show_q;
   logic                   show_next;
   logic                   entry_chg;
   logic [NUM_BUTTONS-1:0] press_q;
   logic                   entry_q;

   always_comb begin
      digit_next = digit_q;
      op_next    = op_q;
      show_next  = show_q;
      entry_chg  = 1'b0;

      for (int unsigned i = BTN_A_ONES; i <= BTN_B_TENS; i++) begin
         if (strobe[i]) begin
            digit_next[i] = bcd_inc(digit_q[i]);
            entry_chg     = 1'b1;
         end
      end

      if (strobe[BTN_ADD]) begin
         op_next = OP_ADD;
      end else if (strobe[BTN_SUB]) begin
         op_next = OP_SUB;
      end else if (strobe[BTN_MUL]) begin
         op_next = OP_MUL;
      end else if (strobe[BTN_DIV]) begin
         op_next = OP_DIV;
      end

      if (op_next != op_q) begin
         entry_chg = 1'b1;
      end

      if (|strobe[BTN_DIV:BTN_A_ONES]) begin
         show_next = 1'b0;
      end else if (strobe[BTN_SHOW]) begin
         show_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         digit_q <= '{default: '0};
         op_q    <= OP_ADD;
         show_q  <= 1'b0;
         press_q <= '0;
         entry_q <= 1'b0;
      end else begin
         digit_q <= digit_next;
         op_q    <= op_next;
         show_q  <= show_next;
         press_q <= strobe;
         entry_q <= entry_chg;
      end
   end

   assign opAOnes      = digit_q[BTN_A_ONES];
   assign opATens      = digit_q[BTN_A_TENS];
   assign opBOnes      = digit_q[BTN_B_ONES];
   assign opBTens      = digit_q[BTN_B_TENS];
   assign opSel        = op_q;
   assign showResult   = show_q;
   assign pressPulse   = press_q;
   assign entryChanged = entry_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with short debounce/repeat timing.
module tb_keypad_entry;

   logic       clk = 1'b0;
   logic       resetN;
   logic [8:0] buttons;
   logic [3:0] opAOnes;
   logic [3:0] opATens;
   logic [3:0] opBOnes;
   logic [3:0] opBTens;
   logic [1:0] opSel;
   logic       showResult;
   logic [8:0] pressPulse;
   logic       entryChanged;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   keypad_entry #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .buttons      (buttons),
      .opAOnes      (opAOnes),
      .opATens      (opATens),
      .opBOnes      (opBOnes),
      .opBTens      (opBTens),
      .opSel        (opSel),
      .showResult   (showResult),
      .pressPulse   (pressPulse),
      .entryChanged (entryChanged)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic press_release(input int idx, output int pulses);
      pulses = 0;
      buttons[idx] = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c == 8) buttons[idx] = 1'b0;
         step(1);
         if (pressPulse[idx]) pulses++;
      end
   endtask

   function automatic logic [29:0] all_outs();
      return {opAOnes, opATens, opBOnes, opBTens, opSel, showResult, pressPulse, entryChanged};
   endfunction

   task automatic test_reset();
      resetN  = 1'b0;
      buttons = '0;
      step(3);
      checks++; if (all_outs() !== '0) $display("FAIL reset_during: got %h expected 0", all_outs()); else passes++;
      resetN = 1'b1;
      step(2);
      checks++; if (all_outs() !== '0) $display("FAIL reset_after: got %h expected 0", all_outs()); else passes++;
   endtask

   task automatic test_single_press();
      int cnt;
      buttons[0] = 1'b1;
      step(6);
      checks++; if (pressPulse !== 9'h000) $display("FAIL single_early: got %h expected 000", pressPulse); else passes++;
      step(1);
      checks++; if (pressPulse !== 9'h001) $display("FAIL single_pulse: got %h expected 001", pressPulse); else passes++;
      checks++; if (opAOnes !== 4'd1) $display("FAIL single_digit: got %0d expected 1", opAOnes); else passes++;
      checks++; if (entryChanged !== 1'b1) $display("FAIL single_entry: got %b expected 1", entryChanged); else passes++;
      step(1);
      checks++; if (pressPulse !== 9'h000) $display("FAIL single_pulse_end: got %h expected 000", pressPulse); else passes++;
      checks++; if (entryChanged !== 1'b0) $display("FAIL single_entry_end: got %b expected 0", entryChanged); else passes++;
`ifndef KEYPAD_AUTOREPEAT_EN
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         step(1);
         if (pressPulse[0]) cnt++;
      end
      checks++; if (cnt !== 0) $display("FAIL held_no_repeat: got %0d strobes expected 0", cnt); else passes++;
      checks++; if (opAOnes !== 4'd1) $display("FAIL held_digit: got %0d expected 1", opAOnes); else passes++;
`endif
      buttons[0] = 1'b0;
      step(10);
   endtask

   task automatic test_digit_wrap();
      int p;
      int total;
      logic [3:0] exp;
      total = 0;
      for (int k = 1; k <= 10; k++) begin
         press_release(3, p);
         total += p;
         exp = 4'(k % 10);
         checks++; if (opBTens !== exp) $display("FAIL wrap_step%0d: got %0d expected %0d", k, opBTens, exp); else passes++;
      end
      checks++; if (total !== 10) $display("FAIL wrap_strobes: got %0d expected 10", total); else passes++;
   endtask

   task automatic test_glitch();
      int p;
      buttons[1] = 1'b1;
      step(3);
      buttons[1] = 1'b0;
      p = 0;
      for (int c = 0; c < 12; c++) begin
         step(1);
         if (pressPulse[1]) p++;
      end
      checks++; if (p !== 0) $display("FAIL glitch_strobes: got %0d expected 0", p); else passes++;
      checks++; if (opATens !== 4'd0) $display("FAIL glitch_digit: got %0d expected 0", opATens); else passes++;
   endtask

   task automatic test_operator_show();
      int p;
      press_release(6, p);
      checks++; if (p !== 1) $display("FAIL mul_strobes: got %0d expected 1", p); else passes++;
      checks++; if (opSel !== 2'b10) $display("FAIL mul_opsel: got %b expected 10", opSel); else passes++;
      press_release(8, p);
      checks++; if (showResult !== 1'b1) $display("FAIL show_set: got %b expected 1", showResult); else passes++;
      checks++; if (opSel !== 2'b10) $display("FAIL show_opsel: got %b expected 10", opSel); else passes++;

      buttons[5] = 1'b1;
      buttons[7] = 1'b1;
      step(7);
      checks++; if (pressPulse !== 9'h0A0) $display("FAIL subdiv_pulse: got %h expected 0a0", pressPulse); else passes++;
      checks++; if (opSel !== 2'b01) $display("FAIL subdiv_opsel: got %b expected 01", opSel); else passes++;
      checks++; if (entryChanged !== 1'b1) $display("FAIL subdiv_entry: got %b expected 1", entryChanged); else passes++;
      checks++; if (showResult !== 1'b0) $display("FAIL subdiv_show: got %b expected 0", showResult); else passes++;
      buttons[5] = 1'b0;
      buttons[7] = 1'b0;
      step(10);

      press_release(8, p);
      buttons[5] = 1'b1;
      step(7);
      checks++; if (pressPulse !== 9'h020) $display("FAIL samesel_pulse: got %h expected 020", pressPulse); else passes++;
      checks++; if (entryChanged !== 1'b0) $display("FAIL samesel_entry: got %b expected 0", entryChanged); else passes++;
      checks++; if (showResult !== 1'b0) $display("FAIL samesel_show: got %b expected 0", showResult); else passes++;
      buttons[5] = 1'b0;
      step(10);

      press_release(8, p);
      press_release(1, p);
      checks++; if (showResult !== 1'b0) $display("FAIL digit_clears_show: got %b expected 0", showResult); else passes++;
      checks++; if (opATens !== 4'd1) $display("FAIL digit_tens: got %0d expected 1", opATens); else passes++;

      press_release(8, p);
      buttons[8] = 1'b1;
      buttons[0] = 1'b1;
      buttons[2] = 1'b1;
      step(7);
      checks++; if (pressPulse !== 9'h105) $display("FAIL entry_wins_pulse: got %h expected 105", pressPulse); else passes++;
      checks++; if (showResult !== 1'b0) $display("FAIL entry_wins_show: got %b expected 0", showResult); else passes++;
      checks++; if (opAOnes !== 4'd2) $display("FAIL multi_a_ones: got %0d expected 2", opAOnes); else passes++;
      checks++; if (opBOnes !== 4'd1) $display("FAIL multi_b_ones: got %0d expected 1", opBOnes); else passes++;
      buttons[8] = 1'b0;
      buttons[0] = 1'b0;
      buttons[2] = 1'b0;
      step(10);
   endtask

   task automatic test_reset_mid_debounce();
      buttons[2] = 1'b1;
      step(4);
      resetN = 1'b0;
      step(1);
      checks++; if (all_outs() !== '0) $display("FAIL midrst_during: got %h expected 0", all_outs()); else passes++;
      resetN = 1'b1;
      step(6);
      checks++; if (all_outs() !== '0) $display("FAIL midrst_early: got %h expected 0", all_outs()); else passes++;
      step(1);
      checks++; if (pressPulse !== 9'h004) $display("FAIL midrst_pulse: got %h expected 004", pressPulse); else passes++;
      checks++; if (opBOnes !== 4'd1) $display("FAIL midrst_digit: got %0d expected 1", opBOnes); else passes++;
      step(1);
      checks++; if (pressPulse !== 9'h000) $display("FAIL midrst_single: got %h expected 000", pressPulse); else passes++;
      buttons[2] = 1'b0;
      step(10);
   endtask

`ifdef KEYPAD_AUTOREPEAT_EN
   task automatic test_autorepeat();
      logic [40:0] seen;
      logic [40:0] exp;
      resetN = 1'b0;
      step(2);
      resetN = 1'b1;
      exp = '0;
      exp[0] = 1'b1; exp[10] = 1'b1; exp[15] = 1'b1;
      exp[20] = 1'b1; exp[25] = 1'b1; exp[30] = 1'b1;
      seen = '0;
      buttons[0] = 1'b1;
      step(7);
      seen[0] = pressPulse[0];
      for (int off = 1; off <= 40; off++) begin
         step(1);
         seen[off] = pressPulse[0];
         if (off == 27) buttons[0] = 1'b0;
      end
      checks++; if (seen !== exp) $display("FAIL repeat_offsets: got %h expected %h", seen, exp); else passes++;
      checks++; if (opAOnes !== 4'd6) $display("FAIL repeat_digit: got %0d expected 6", opAOnes); else passes++;
   endtask
`endif

   initial begin
      resetN  = 1'b0;
      buttons = '0;
      test_reset();
      test_single_press();
      test_digit_wrap();
      test_glitch();
      test_operator_show();
      test_reset_mid_debounce();
`ifdef KEYPAD_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side front end for the calculator: conditions the nine raw push-buttons and presents clean operand digits, the operator selection and the display mode to the arithmetic and seven-segment blocks. It synchronizes and debounces every button and converts each press into a single-cycle strobe. It also holds the four BCD operand digits (wrapping 0..9), the latched operator code and the show-result flag.

## Interface
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a level change (1 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50000000: hold time before the first auto-repeat. Used only with KEYPAD_AUTOREPEAT_EN.
- REPEAT_PERIOD, 20000000: interval between subsequent auto-repeats. Used only with KEYPAD_AUTOREPEAT_EN.
- clk  in  1  system clock; all logic on rising edge.
- resetN  in  1  reset, synchronous, active-low.
- buttons  in  9  raw asynchronous buttons. [0] opA ones, [1] opA tens, [2] opB ones, [3] opB tens, [4] add, [5] sub, [6] mul, [7] div, [8] show.
- opAOnes, opATens, opBOnes, opBTens  out  4 each  BCD operand digits, always 0..9.
- opSel  out  2  operator code: 00 add, 01 sub, 10 mul, 11 div.
- showResult  out  1  1 = display result, 0 = display operand entry.
- pressPulse  out  9  one-cycle strobe per accepted press (or auto-repeat).
- entryChanged  out  1  one-cycle strobe when any digit or opSel changed.

## Operation
- Per button: 2-flop synchronizer, then debouncer.
  - A debounced state flips after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
- pressPulse[i] = rising edge of debounced state i. Releases produce no strobe.
- Digit buttons 0..3: the matching digit increments on its strobe, 9 -> 0.
- Operator buttons 4..7: the strobe loads opSel.
  - If several operator strobes fire in the same cycle, the lowest index wins.
  - Loading the current value still strobes pressPulse but not entryChanged.
- Button 8 strobe sets showResult = 1.
- Any digit or operator strobe clears showResult = 0. If it fires in the same cycle as button 8, entry wins (showResult = 0).
- Several digit strobes in one cycle: every addressed digit increments independently.
- Reset values:
  - All digits 0, opSel 00, showResult 0, pressPulse 0, entryChanged 0.
  - Synchronizers, debounced states and counters 0.
- A button held through reset release is treated as a new press and strobes once after full debounce.
- Reset asserted mid-debounce discards the count. Reset wins over any same-cycle strobe.

## Timing
- Raw input steady from cycle 0 (first sampling edge): synchronized at cycle 2, debounced state set at cycle 2+DEBOUNCE_CYCLES.
- pressPulse, the digit/opSel/showResult update and entryChanged all register on that same edge: visible in cycle 2+DEBOUNCE_CYCLES+1.
- Glitches shorter than DEBOUNCE_CYCLES produce no strobe.
- Strobes last exactly one cycle. A held button gives one strobe (without auto-repeat).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined: digit buttons 0..3 auto-repeat while held.
  - The first extra strobe comes REPEAT_DELAY cycles after the press strobe, then one every REPEAT_PERIOD cycles.
  - Repeat strobes behave exactly like presses.
  - Release or reset cancels the repeat timer.
  - Operator and show buttons never repeat.
- Not defined: no repeat logic or timers synthesized; REPEAT_* parameters ignored; one strobe per press.

## Structure
- Package keypad_pkg holds:
  - op_t enum (OP_ADD=2'b00, OP_SUB, OP_MUL, OP_DIV);
  - button index constants BTN_A_ONES..BTN_SHOW;
  - DIGIT_MAX = 4'd9; NUM_BUTTONS = 9.
- Sub-module button_debouncer: one button's synchronizer, counter, debounced state and rising-edge strobe. Instantiated 9 times by generate.
- Digit counters, operator latch, show flag and the optional repeat timers live in keypad_entry.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset, then hold buttons[0] high -> one pressPulse[0] in cycle 7; opAOnes 0 -> 1; entryChanged pulses; no further strobes while held (macro off).
- Ten clean presses of buttons[3] -> opBTens counts 1..9, then 0; exactly 10 strobes.
- buttons[1] high for 3 cycles, then low -> no strobe, opATens stays 0.
- buttons[6] press, then buttons[8] press -> opSel=10, then showResult=1. Same-cycle buttons[5]+buttons[7] -> opSel=01. Digit press -> showResult=0.
- Hold buttons[2]; assert resetN low for 1 cycle mid-debounce (count 2); keep holding -> all outputs 0 during and after reset; single strobe 7 cycles after reset release; opBOnes=1.
- With KEYPAD_AUTOREPEAT_EN, hold buttons[0] for 30 cycles after first strobe -> strobes at +0, +10, +15, +20, +25, +30; opAOnes=6; release stops repeats.
